alu_issue_unit: RTL and testbench
=================================

// Module: alu_issue_unit
// PURPOSE
// - Sequential front end for the combinational ALU. Accepts 32-bit instruction words over a valid/ready handshake.
// - Decodes each word, reads a 16x32 register file and drives the ALU operand/control ports from registers.
// - Captures the ALU result, flags and condition-met status, then writes back and retires.
// - Throughput is one instruction per 2 cycles.
// PARAMETERS
// - DATA_W     32    operand/result width; fixed by the encoding, only 32 is legal.
// - REG_AW     4     register address width; the file holds 2**REG_AW = 16 entries.
// - FLAGS_RST  4'h0  reset value of the architectural flags register.
// PORTS
// - clk           in   1   single clock, rising edge.
// - rst_n         in   1   asynchronous active-low reset.
// - instr_valid   in   1   instruction word offered.
// - instr_ready   out  1   unit can accept; high in IDLE and WB (combinational from state).
// - instr         in   32  [31:28] op, [27:24] cond, [23] S, [22:19] Rd, [18:15] Rn, [14:11] Rm,
//                          [10:8] sr_cont, [7:3] sr_bit, [15:0] imm16 (MOVI only), [2:0] reserved.
// - alu_in1       out  32  registered value of Rn.
// - alu_in2       out  32  registered value of Rm.
// - alu_opcode    out  4   registered op.
// - alu_cond      out  4   registered cond.
// - alu_s         out  1   registered S.
// - alu_sr_cont   out  3   registered shift/rotate control.
// - alu_sr_bit    out  5   registered shift amount.
// - alu_imm       out  16  registered imm16.
// - alu_out       in   32  ALU result.
// - alu_flags     in   4   ALU flags.
// - alu_cond_met  in   1   ALU condition-met.
// - flags_q       out  4   architectural flags.
// - retire_valid  out  1   one-cycle pulse in WB.
// - retire_wen    out  1   register write performed this retire.
// - retire_rd     out  4   retiring Rd.
// - retire_data   out  32  retiring result.
// - illegal       out  1   illegal-op pulse; only with ILLEGAL_TRAP_EN, else tied 0.
// - dbg_addr      in   4   debug read address.
// - dbg_data      out  32  combinational regfile[dbg_addr]; shows the post-write value.
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - state=IDLE; all regfile entries 0; flags_q=FLAGS_RST.
//   - All alu_* outputs and all retire_* outputs 0.
//   - Reset mid-operation abandons the instruction: no write, no retire.
// - Handshake: accept = instr_valid & instr_ready. The offered instr is held until accepted; no skid buffer.
// - IDLE -> EXEC on accept. Decoded fields and operands regfile[Rn], regfile[Rm] are registered onto the alu_* ports.
// - EXEC (ready=0):
//   - ALU settles combinationally.
//   - At the clock edge, capture res_q=alu_out, cm_q=alu_cond_met, fl_q=alu_flags.
//   - Always -> WB.
// - WB (ready=1):
//   - retire_valid=1.
//   - Writeback enable we = cm_q & op in {0000-0111, 1101}. CMP(1011) and STR(1110) never write.
//   - If we, regfile[Rd] <= res_q at the WB edge.
//   - flags_q <= fl_q if cm_q & (S | op==1011).
//   - Next state: EXEC if accept, else IDLE.
// - Forwarding:
//   - An instruction accepted in WB whose Rn/Rm equals a Rd being written that cycle receives res_q, not the stale entry.
//   - Rn==Rm==Rd all forward.
// - Latency: accept -> retire_valid is exactly 2 cycles. Back-to-back issue every 2 cycles.
// - Condition failure: ALU returns 0 and cm_q=0, so retire_valid=1, retire_wen=0, no flag update.
// - Reserved bits [2:0] are ignored. For MOVI, the Rn/Rm fields overlap imm16 and are read but unused.
// CONFIGURATION
// - ILLEGAL_TRAP_EN defined:
//   - Ops 1000, 1001, 1010, 1100, 1111 pulse illegal=1 in WB alongside retire_valid.
//   - Writeback and flag update are suppressed.
// - ILLEGAL_TRAP_EN undefined:
//   - These ops retire as a NOP (retire_wen=0, no flag update); illegal is tied 0.
// TESTING
// - Reset: rst_n=0 mid-EXEC -> next cycle state=IDLE, instr_ready=1, all retire_*=0, dbg_data(any)=0.
// - MOVI R1,0x1234; ADD R2,R1,R1 back-to-back -> retire 1: R1=0x1234; retire 2: alu_in1=alu_in2=0x1234 (forwarded), R2=0x2468.
// - CMP R1,R2 with R1=5, R2=5 -> retire_wen=0, flags_q=alu_flags, R1/R2 unchanged.
// - ADD cond=EQ(0001) with R1=3, R2=4 -> alu_cond_met=0, retire_valid=1, retire_wen=0, flags_q unchanged.
// - instr_valid held high for 10 cycles -> exactly 5 accepts; instr_ready pattern 1,0,1,0...
// - op=1111 -> with ILLEGAL_TRAP_EN: illegal pulse, no write; without it: illegal=0, NOP retire.

Source files
------------

// File: rtl/alu_issue_unit.sv
// Sequential issue/writeback front end for the combinational ALU: IDLE -> EXEC -> WB, one instruction per 2 cycles.
// Optional macro ILLEGAL_TRAP_EN: ops 1000/1001/1010/1100/1111 raise an illegal pulse in WB instead of retiring silently.
module alu_issue_unit #(
  parameter int          DATA_W    = 32,
  parameter int          REG_AW    = 4,
  parameter logic [3:0]  FLAGS_RST = 4'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [3:0]        alu_opcode,
  output logic [3:0]        alu_cond,
  output logic              alu_s,
  output logic [2:0]        alu_sr_cont,
  output logic [4:0]        alu_sr_bit,
  output logic [15:0]       alu_imm,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [3:0]        alu_flags,
  input  logic              alu_cond_met,
  output logic [3:0]        flags_q,
  output logic              retire_valid,
  output logic              retire_wen,
  output logic [REG_AW-1:0] retire_rd,
  output logic [DATA_W-1:0] retire_data,
  output logic              illegal,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   regs [2**REG_AW];
  logic [DATA_W-1:0]   res_q;
  logic                cm_q;
  logic [3:0]          fl_q;
  logic [REG_AW-1:0]   rd_q;

  logic                accept, in_wb, in_exec;
  logic                writes_rd, is_cmp, is_illegal, we, flag_we;
  logic [REG_AW-1:0]   dec_rd, dec_rn, dec_rm;
  logic [DATA_W-1:0]   opnd_rn, opnd_rm;
  logic                unused_rsvd;

  assign dec_rd      = instr[22:19];
  assign dec_rn      = instr[18:15];
  assign dec_rm      = instr[14:11];
  assign unused_rsvd = ^instr[2:0];

  assign in_wb       = (state == WB);
  assign in_exec     = (state == EXEC);
  assign instr_ready = (state == IDLE) || in_wb;
  assign accept      = instr_valid && instr_ready;

  // Classification always refers to the instruction currently in flight (held on alu_opcode).
  assign writes_rd  = (alu_opcode[3] == 1'b0) || (alu_opcode == 4'hD);
  assign is_cmp     = (alu_opcode == 4'hB);
  assign is_illegal = (alu_opcode == 4'h8) || (alu_opcode == 4'h9) || (alu_opcode == 4'hA) ||
                      (alu_opcode == 4'hC) || (alu_opcode == 4'hF);
  assign we         = in_wb && cm_q && writes_rd && !is_illegal;
  assign flag_we    = in_wb && cm_q && (alu_s || is_cmp) && !is_illegal;

  // A new instruction accepted in WB must see the result being written this same edge.
  assign opnd_rn = (we && (rd_q == dec_rn)) ? res_q : regs[dec_rn];
  assign opnd_rm = (we && (rd_q == dec_rm)) ? res_q : regs[dec_rm];

  assign retire_valid = in_wb;
  assign retire_wen   = we;
  assign retire_rd    = in_wb ? rd_q  : '0;
  assign retire_data  = in_wb ? res_q : '0;
  assign dbg_data     = regs[dbg_addr];

`ifdef ILLEGAL_TRAP_EN
  assign illegal = in_wb && is_illegal;
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = accept ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in1     <= '0;
      alu_in2     <= '0;
      alu_opcode  <= '0;
      alu_cond    <= '0;
      alu_s       <= 1'b0;
      alu_sr_cont <= '0;
      alu_sr_bit  <= '0;
      alu_imm     <= '0;
      rd_q        <= '0;
    end else if (accept) begin
      alu_in1     <= opnd_rn;
      alu_in2     <= opnd_rm;
      alu_opcode  <= instr[31:28];
      alu_cond    <= instr[27:24];
      alu_s       <= instr[23];
      alu_sr_cont <= instr[10:8];
      alu_sr_bit  <= instr[7:3];
      alu_imm     <= instr[15:0];
      rd_q        <= dec_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      cm_q  <= 1'b0;
      fl_q  <= '0;
    end else if (in_exec) begin
      res_q <= alu_out;
      cm_q  <= alu_cond_met;
      fl_q  <= alu_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
      flags_q <= FLAGS_RST;
    end else begin
      if (we)      regs[rd_q] <= res_q;
      if (flag_we) flags_q    <= fl_q;
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed self-checking bench for alu_issue_unit with a tiny behavioural ALU model on the alu_* ports.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic [3:0]  alu_opcode, alu_cond, alu_flags, flags_q;
  logic        alu_s, alu_cond_met;
  logic [2:0]  alu_sr_cont;
  logic [4:0]  alu_sr_bit;
  logic [15:0] alu_imm;
  logic        retire_valid, retire_wen, illegal;
  logic [3:0]  retire_rd, dbg_addr;
  logic [31:0] retire_data, dbg_data;

  int testCount = 0;
  int failCount = 0;

  alu_issue_unit dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode), .alu_cond(alu_cond),
    .alu_s(alu_s), .alu_sr_cont(alu_sr_cont), .alu_sr_bit(alu_sr_bit), .alu_imm(alu_imm),
    .alu_out(alu_out), .alu_flags(alu_flags), .alu_cond_met(alu_cond_met),
    .flags_q(flags_q),
    .retire_valid(retire_valid), .retire_wen(retire_wen), .retire_rd(retire_rd),
    .retire_data(retire_data), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // ALU model: cond 0 = always, cond 1 = operands equal; ADD=0100, SUB=0010, CMP=1011, MOVI=1101.
  logic [31:0] raw;
  always_comb begin
    raw = alu_in1 ^ alu_in2;
    case (alu_opcode)
      4'h4:       raw = alu_in1 + alu_in2;
      4'h2, 4'hB: raw = alu_in1 - alu_in2;
      4'hD:       raw = {16'h0, alu_imm};
      default:    raw = alu_in1 ^ alu_in2;
    endcase
    alu_cond_met = (alu_cond == 4'h0) || ((alu_cond == 4'h1) && (alu_in1 == alu_in2));
    alu_out      = alu_cond_met ? raw : 32'h0;
    alu_flags    = (alu_opcode == 4'hF) ? 4'hF : {raw[31], (raw == 32'h0), 2'b00};
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkReg(input string tag, input logic [3:0] addr, input logic [31:0] expected);
    dbg_addr = addr;
    #1;
    checkOutput(tag, dbg_data, expected);
  endtask

  // Offers one word, waits (bounded) for acceptance, returns just after the accepting edge.
  task automatic applyStimulus(input logic [31:0] word);
    int n;
    n = 0;
    @(negedge clk);
    instr       = word;
    instr_valid = 1'b1;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) checkOutput("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic runToWb(input logic [31:0] word);
    applyStimulus(word);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic execute(input logic [31:0] word);
    runToWb(word);
    @(posedge clk);
    #1;
  endtask

  logic [9:0] readyPattern;
  int         acceptCount;

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = 32'h0; dbg_addr = 4'h0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", instr_ready, 1);
    checkOutput("rst_retire", {retire_valid, retire_wen, retire_rd, retire_data}, 0);
    checkOutput("rst_flags", flags_q, 4'h0);
    checkReg("rst_r5", 4'd5, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // MOVI R1,0x1234 then ADD R2,R1,R1 back-to-back, operands forwarded.
    @(negedge clk);
    instr = 32'hD008_1234; instr_valid = 1'b1;
    @(negedge clk);
    instr = 32'h4010_8800;
    @(negedge clk);
    checkOutput("movi_retire_valid", retire_valid, 1);
    checkOutput("movi_retire_wen", retire_wen, 1);
    checkOutput("movi_retire_rd", retire_rd, 4'd1);
    checkOutput("movi_retire_data", retire_data, 32'h1234);
    @(negedge clk);
    instr_valid = 1'b0;
    checkOutput("fwd_in1", alu_in1, 32'h1234);
    checkOutput("fwd_in2", alu_in2, 32'h1234);
    checkReg("movi_r1", 4'd1, 32'h1234);
    @(negedge clk);
    checkOutput("add_retire_rd", retire_rd, 4'd2);
    checkOutput("add_retire_data", retire_data, 32'h2468);
    @(posedge clk); #1;
    checkReg("add_r2", 4'd2, 32'h2468);

    // CMP R1,R2 with equal operands: Z set, no write.
    execute(32'hD008_0005);
    execute(32'hD010_0005);
    runToWb(32'hB018_9000);
    checkOutput("cmp_valid", retire_valid, 1);
    checkOutput("cmp_wen", retire_wen, 0);
    @(posedge clk); #1;
    checkOutput("cmp_flags", flags_q, 4'h4);
    checkReg("cmp_r1", 4'd1, 32'h5);
    checkReg("cmp_r2", 4'd2, 32'h5);
    checkReg("cmp_r3", 4'd3, 32'h0);

    // ADDS EQ R5,R1,R2 with 3 != 4: condition fails, nothing changes.
    execute(32'hD008_0003);
    execute(32'hD010_0004);
    runToWb(32'h41A8_9000);
    checkOutput("eq_cond_met", alu_cond_met, 0);
    checkOutput("eq_valid", retire_valid, 1);
    checkOutput("eq_wen", retire_wen, 0);
    @(posedge clk); #1;
    checkOutput("eq_flags", flags_q, 4'h4);
    checkReg("eq_r5", 4'd5, 32'h0);

    // ADDS R6,R1,R2 always: writes 7 and clears flags via S.
    execute(32'h40B0_9000);
    checkReg("adds_r6", 4'd6, 32'h7);
    checkOutput("adds_flags", flags_q, 4'h0);

    // Valid held for 10 cycles: ready alternates, 5 accepts.
    @(negedge clk);
    instr = 32'hD038_0001; instr_valid = 1'b1;
    readyPattern = '0; acceptCount = 0;
    for (int i = 0; i < 10; i++) begin
      readyPattern = {readyPattern[8:0], instr_ready};
      if (instr_ready) acceptCount++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("stream_accepts", acceptCount, 5);
    checkOutput("stream_ready", readyPattern, 10'b1010101010);
    checkReg("stream_r7", 4'd7, 32'h1);

    // op 1111 with S set: illegal in trap build, NOP otherwise; never writes or updates flags.
    runToWb(32'hF0C0_9000);
    checkOutput("ill_valid", retire_valid, 1);
    checkOutput("ill_wen", retire_wen, 0);
`ifdef ILLEGAL_TRAP_EN
    checkOutput("ill_pulse", illegal, 1);
`else
    checkOutput("ill_pulse", illegal, 0);
`endif
    @(posedge clk); #1;
    checkOutput("ill_after", illegal, 0);
    checkOutput("ill_flags", flags_q, 4'h0);
    checkReg("ill_r8", 4'd8, 32'h0);

    // Reset while in EXEC abandons the instruction.
    applyStimulus(32'h4048_9000);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_ready", instr_ready, 1);
    checkOutput("midrst_retire", {retire_valid, retire_wen, retire_rd, retire_data}, 0);
    checkOutput("midrst_flags", flags_q, 4'h0);
    checkReg("midrst_r1", 4'd1, 32'h0);
    checkReg("midrst_r9", 4'd9, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midrst_no_retire", retire_valid, 0);
    checkReg("midrst_r9_late", 4'd9, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
